// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file slave: NUM_REGS words with byte strobes, a read-only mask,
// independently buffered AW/W channels and SLVERR/DECERR responses.
module axi4lite_regfile_slave #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                    A_CLK,
  input  logic                    A_RSTn,
  input  logic                    AW_VALID,
  output logic                    AW_READY,
  input  logic [ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic [2:0]              AW_PROT,
  input  logic                    W_VALID,
  output logic                    W_READY,
  input  logic [DATA_WIDTH-1:0]   W_DATA,
  input  logic [DATA_WIDTH/8-1:0] W_STRB,
  output logic                    B_VALID,
  input  logic                    B_READY,
  output logic [1:0]              B_RESP,
  input  logic                    AR_VALID,
  output logic                    AR_READY,
  input  logic [ADDR_WIDTH-1:0]   AR_ADDR,
  input  logic [2:0]              AR_PROT,
  output logic                    R_VALID,
  input  logic                    R_READY,
  output logic [DATA_WIDTH-1:0]   R_DATA,
  output logic [1:0]              R_RESP
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFF_W;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IDX_W:0] NUM_REGS_X = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  aw_full_q, aw_full_d;
  logic [IDX_W-1:0]      aw_idx_q;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;
  logic                  b_valid_q, b_valid_d;
  logic [1:0]            b_resp_q, b_resp_d;
  logic                  r_valid_q, r_valid_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic                  aw_hs, w_hs, ar_hs, commit, wr_en;
  logic [IDX_W-1:0]      ar_idx;
  logic [SEL_W-1:0]      wr_sel, rd_sel;
  logic                  unused_sink;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < NUM_REGS_X;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] cur,
                                                        input logic [DATA_WIDTH-1:0] upd,
                                                        input logic [STRB_W-1:0]     strb);
    logic [DATA_WIDTH-1:0] res;
    res = cur;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) res[8*b +: 8] = upd[8*b +: 8];
    end
    return res;
  endfunction

  // Readies are forced low while reset is asserted, independent of buffer state
  assign AW_READY = A_RSTn & ~aw_full_q;
  assign W_READY  = A_RSTn & ~w_full_q;
  assign AR_READY = A_RSTn & (~r_valid_q | R_READY);

  assign aw_hs  = AW_VALID & AW_READY;
  assign w_hs   = W_VALID & W_READY;
  assign ar_hs  = AR_VALID & AR_READY;
  assign commit = aw_full_q & w_full_q & (~b_valid_q | B_READY);
  assign wr_sel = aw_idx_q[SEL_W-1:0];
  assign ar_idx = AR_ADDR[ADDR_WIDTH-1:OFF_W];
  assign rd_sel = ar_idx[SEL_W-1:0];
  assign wr_en  = commit & in_range(aw_idx_q) & ~RO_MASK[wr_sel];

  assign unused_sink = ^{AW_PROT, AR_PROT, AW_ADDR[OFF_W-1:0], AR_ADDR[OFF_W-1:0]};

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    b_valid_d = b_valid_q;
    b_resp_d  = b_resp_q;
    if (aw_hs) aw_full_d = 1'b1;
    if (w_hs) w_full_d = 1'b1;
    if (B_READY) b_valid_d = 1'b0;
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      b_valid_d = 1'b1;
      if (!in_range(aw_idx_q))   b_resp_d = RESP_DECERR;
      else if (RO_MASK[wr_sel])  b_resp_d = RESP_SLVERR;
      else                       b_resp_d = RESP_OKAY;
    end
  end

  // Reads sample regs_q before this edge's write lands, so a colliding read sees the old value
  always_comb begin
    r_valid_d = r_valid_q;
    r_resp_d  = r_resp_q;
    r_data_d  = r_data_q;
    if (R_READY) r_valid_d = 1'b0;
    if (ar_hs) begin
      r_valid_d = 1'b1;
      if (in_range(ar_idx)) begin
        r_data_d = regs_q[rd_sel];
        r_resp_d = RESP_OKAY;
      end else begin
        r_data_d = '0;
        r_resp_d = RESP_DECERR;
      end
    end
  end

  always_ff @(posedge A_CLK) begin
    if (!A_RSTn) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      b_valid_q <= 1'b0;
      b_resp_q  <= RESP_OKAY;
      r_valid_q <= 1'b0;
      r_resp_q  <= RESP_OKAY;
      r_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      b_valid_q <= b_valid_d;
      b_resp_q  <= b_resp_d;
      r_valid_q <= r_valid_d;
      r_resp_q  <= r_resp_d;
      r_data_q  <= r_data_d;
      if (wr_en) regs_q[wr_sel] <= merge_bytes(regs_q[wr_sel], w_data_q, w_strb_q);
    end
  end

  // Holding-buffer payloads only matter while their full flag is set
  always_ff @(posedge A_CLK) begin
    if (aw_hs) aw_idx_q <= AW_ADDR[ADDR_WIDTH-1:OFF_W];
    if (w_hs) begin
      w_data_q <= W_DATA;
      w_strb_q <= W_STRB;
    end
  end

  assign B_VALID = b_valid_q;
  assign B_RESP  = b_resp_q;
  assign R_VALID = r_valid_q;
  assign R_RESP  = r_resp_q;
  assign R_DATA  = r_data_q;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Directed bench for axi4lite_regfile_slave: 32-bit data, 16 registers, register 2 read-only.
module tb_axi4lite_regfile_slave;
  logic        clk = 1'b0;
  logic        A_RSTn;
  logic        AW_VALID, AW_READY;
  logic [7:0]  AW_ADDR;
  logic [2:0]  AW_PROT;
  logic        W_VALID, W_READY;
  logic [31:0] W_DATA;
  logic [3:0]  W_STRB;
  logic        B_VALID, B_READY;
  logic [1:0]  B_RESP;
  logic        AR_VALID, AR_READY;
  logic [7:0]  AR_ADDR;
  logic [2:0]  AR_PROT;
  logic        R_VALID, R_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;

  int passed = 0;
  int total  = 0;

  axi4lite_regfile_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REGS(16), .RO_MASK(16'h0004)
  ) dut (
    .A_CLK(clk), .A_RSTn(A_RSTn),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output bit ok);
    bit aw_done, w_done;
    aw_done = 0; w_done = 0; ok = 0; resp = 2'bxx;
    AW_ADDR = a; W_DATA = d; W_STRB = s; AW_VALID = 1; W_VALID = 1; B_READY = 1;
    for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
      if (AW_VALID && AW_READY) aw_done = 1;
      if (W_VALID && W_READY) w_done = 1;
      tick();
      if (aw_done) AW_VALID = 0;
      if (w_done) W_VALID = 0;
    end
    AW_VALID = 0; W_VALID = 0;
    for (int n = 0; n < 20; n++) begin
      if (B_VALID) begin
        resp = B_RESP;
        tick();
        ok = aw_done && w_done;
        break;
      end
      tick();
    end
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit ok);
    bit done;
    done = 0;
    AR_ADDR = a; AR_VALID = 1; R_READY = 1;
    for (int n = 0; n < 20; n++) begin
      if (AR_READY) begin
        tick();
        done = 1;
        break;
      end
      tick();
    end
    AR_VALID = 0;
    ok = done && R_VALID;
    d = R_DATA; resp = R_RESP;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; bit ok;
    A_RSTn = 0; tick(); tick();
    total++;
    if ({AW_READY, W_READY, AR_READY} !== 3'b000)
      $display("FAIL reset_ready_low: got %b expected 000", {AW_READY, W_READY, AR_READY});
    else passed++;
    total++;
    if ({B_VALID, R_VALID, B_RESP, R_RESP, R_DATA} !== 38'd0)
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%h expected all zero",
               B_VALID, R_VALID, B_RESP, R_RESP, R_DATA);
    else passed++;
    A_RSTn = 1; #1;
    total++;
    if ({AW_READY, W_READY, AR_READY} !== 3'b111)
      $display("FAIL release_ready_high: got %b expected 111", {AW_READY, W_READY, AR_READY});
    else passed++;
    do_read(8'h04, d, r, ok);
    total++;
    if (!ok || d !== 32'h0 || r !== 2'b00)
      $display("FAIL reset_read_04: got ok=%0d %h/%b expected 00000000/00", ok, d, r);
    else passed++;
  endtask

  task automatic test_write_basic();
    AW_ADDR = 8'h04; W_DATA = 32'hDEADBEEF; W_STRB = 4'hF;
    AW_VALID = 1; W_VALID = 1; B_READY = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    total++;
    if (B_VALID !== 1'b0) $display("FAIL b_not_early: got %b expected 0", B_VALID);
    else passed++;
    tick();
    total++;
    if ({B_VALID, B_RESP} !== 3'b100)
      $display("FAIL b_okay_latency: got %b expected 100", {B_VALID, B_RESP});
    else passed++;
    AR_ADDR = 8'h04; AR_VALID = 1; R_READY = 1;
    tick();
    AR_VALID = 0;
    total++;
    if ({R_VALID, R_RESP, R_DATA} !== {1'b1, 2'b00, 32'hDEADBEEF})
      $display("FAIL read_after_write: got %b/%b/%h expected 1/00/deadbeef", R_VALID, R_RESP, R_DATA);
    else passed++;
    total++;
    if (B_VALID !== 1'b0) $display("FAIL b_handshake_clears: got %b expected 0", B_VALID);
    else passed++;
    tick();
  endtask

  task automatic test_strobe_w_first();
    logic [31:0] d; logic [1:0] r; bit ok;
    W_DATA = 32'h11223344; W_STRB = 4'b0101; W_VALID = 1; B_READY = 1;
    tick();
    W_VALID = 0;
    total++;
    if (W_READY !== 1'b0) $display("FAIL w_buffered_ready: got %b expected 0", W_READY);
    else passed++;
    tick();
    AW_ADDR = 8'h04; AW_VALID = 1;
    tick();
    AW_VALID = 0;
    total++;
    if ({W_READY, B_VALID} !== 2'b00)
      $display("FAIL w_held_until_commit: got %b expected 00", {W_READY, B_VALID});
    else passed++;
    tick();
    total++;
    if ({W_READY, AW_READY, B_VALID, B_RESP} !== 5'b11100)
      $display("FAIL strobe_commit: got %b expected 11100", {W_READY, AW_READY, B_VALID, B_RESP});
    else passed++;
    tick();
    do_read(8'h04, d, r, ok);
    total++;
    if (!ok || d !== 32'hDE22BE44 || r !== 2'b00)
      $display("FAIL strobe_merge: got ok=%0d %h/%b expected de22be44/00", ok, d, r);
    else passed++;
  endtask

  task automatic test_ro_and_decode();
    logic [31:0] d; logic [1:0] r; bit ok;
    do_write(8'h08, 32'h1, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b10) $display("FAIL ro_slverr: got ok=%0d %b expected 10", ok, r);
    else passed++;
    do_read(8'h08, d, r, ok);
    total++;
    if (!ok || d !== 32'h0 || r !== 2'b00)
      $display("FAIL ro_unchanged: got ok=%0d %h/%b expected 00000000/00", ok, d, r);
    else passed++;
    do_write(8'h40, 32'h55AA55AA, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b11) $display("FAIL wr_decerr: got ok=%0d %b expected 11", ok, r);
    else passed++;
    do_read(8'h40, d, r, ok);
    total++;
    if (!ok || d !== 32'h0 || r !== 2'b11)
      $display("FAIL rd_decerr: got ok=%0d %h/%b expected 00000000/11", ok, d, r);
    else passed++;
    do_read(8'h07, d, r, ok);
    total++;
    if (!ok || d !== 32'hDE22BE44 || r !== 2'b00)
      $display("FAIL unaligned_read: got ok=%0d %h/%b expected de22be44/00", ok, d, r);
    else passed++;
    do_write(8'h04, 32'hFFFFFFFF, 4'h0, r, ok);
    total++;
    if (!ok || r !== 2'b00) $display("FAIL zero_strb_resp: got ok=%0d %b expected 00", ok, r);
    else passed++;
    do_read(8'h04, d, r, ok);
    total++;
    if (!ok || d !== 32'hDE22BE44)
      $display("FAIL zero_strb_nochange: got ok=%0d %h expected de22be44", ok, d);
    else passed++;
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; bit ok;
    AW_ADDR = 8'h0C; W_DATA = 32'hCAFEF00D; W_STRB = 4'hF;
    AW_VALID = 1; W_VALID = 1; B_READY = 1; R_READY = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    AR_ADDR = 8'h0C; AR_VALID = 1;
    tick();
    AR_VALID = 0;
    total++;
    if ({B_VALID, R_VALID, R_DATA} !== {1'b1, 1'b1, 32'h0})
      $display("FAIL collision_old_value: got %b/%b/%h expected 1/1/00000000", B_VALID, R_VALID, R_DATA);
    else passed++;
    tick();
    do_read(8'h0C, d, r, ok);
    total++;
    if (!ok || d !== 32'hCAFEF00D) $display("FAIL collision_new_value: got ok=%0d %h expected cafef00d", ok, d);
    else passed++;
  endtask

  task automatic test_b_backpressure();
    logic [31:0] d; logic [1:0] r; bit ok; bit stuck_ok;
    B_READY = 0;
    AW_ADDR = 8'h10; W_DATA = 32'hA5A5A5A5; W_STRB = 4'hF; AW_VALID = 1; W_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    tick();
    total++;
    if ({B_VALID, B_RESP} !== 3'b100) $display("FAIL bp_first_b: got %b expected 100", {B_VALID, B_RESP});
    else passed++;
    AW_ADDR = 8'h14; W_DATA = 32'h5A5A5A5A; AW_VALID = 1; W_VALID = 1;
    tick();
    AW_VALID = 0; W_VALID = 0;
    stuck_ok = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!(B_VALID && B_RESP == 2'b00 && !AW_READY && !W_READY)) stuck_ok = 0;
    end
    total++;
    if (stuck_ok !== 1'b1)
      $display("FAIL bp_hold: got b=%b aw_rdy=%b w_rdy=%b expected 1/0/0", B_VALID, AW_READY, W_READY);
    else passed++;
    B_READY = 1;
    tick();
    total++;
    if ({B_VALID, AW_READY, W_READY} !== 3'b111)
      $display("FAIL bp_second_commit: got %b expected 111", {B_VALID, AW_READY, W_READY});
    else passed++;
    tick();
    total++;
    if (B_VALID !== 1'b0) $display("FAIL bp_second_done: got %b expected 0", B_VALID);
    else passed++;
    do_read(8'h10, d, r, ok);
    total++;
    if (!ok || d !== 32'hA5A5A5A5) $display("FAIL bp_data1: got ok=%0d %h expected a5a5a5a5", ok, d);
    else passed++;
    do_read(8'h14, d, r, ok);
    total++;
    if (!ok || d !== 32'h5A5A5A5A) $display("FAIL bp_data2: got ok=%0d %h expected 5a5a5a5a", ok, d);
    else passed++;
  endtask

  task automatic test_r_backpressure();
    logic [1:0] r; bit ok; bit stable;
    do_write(8'h00, 32'h01234567, 4'hF, r, ok);
    total++;
    if (!ok || r !== 2'b00) $display("FAIL rbp_setup_write: got ok=%0d %b expected 00", ok, r);
    else passed++;
    R_READY = 0; AR_ADDR = 8'h04; AR_VALID = 1;
    tick();
    AR_ADDR = 8'h00;
    total++;
    if ({R_VALID, R_DATA} !== {1'b1, 32'hDE22BE44})
      $display("FAIL rbp_first: got %b/%h expected 1/de22be44", R_VALID, R_DATA);
    else passed++;
    stable = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (!(R_VALID && R_DATA == 32'hDE22BE44 && R_RESP == 2'b00 && !AR_READY)) stable = 0;
    end
    total++;
    if (stable !== 1'b1)
      $display("FAIL rbp_hold: got r_valid=%b data=%h ar_rdy=%b expected 1/de22be44/0", R_VALID, R_DATA, AR_READY);
    else passed++;
    R_READY = 1;
    tick();
    AR_ADDR = 8'h04;
    total++;
    if ({R_VALID, R_DATA} !== {1'b1, 32'h01234567})
      $display("FAIL b2b_beat0: got %b/%h expected 1/01234567", R_VALID, R_DATA);
    else passed++;
    tick();
    AR_VALID = 0;
    total++;
    if ({R_VALID, R_DATA} !== {1'b1, 32'hDE22BE44})
      $display("FAIL b2b_beat1: got %b/%h expected 1/de22be44", R_VALID, R_DATA);
    else passed++;
    tick();
    total++;
    if (R_VALID !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", R_VALID);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d; logic [1:0] r; bit ok;
    AW_ADDR = 8'h18; W_DATA = 32'h0F0F0F0F; W_STRB = 4'hF; AW_VALID = 1; W_VALID = 1;
    R_READY = 0; AR_ADDR = 8'h04; AR_VALID = 1; B_READY = 1;
    tick();
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
    A_RSTn = 0;
    tick();
    total++;
    if ({AW_READY, W_READY, AR_READY, B_VALID, R_VALID, B_RESP, R_RESP} !== 9'd0 || R_DATA !== 32'h0)
      $display("FAIL midreset_outputs: got %b data=%h expected all zero",
               {AW_READY, W_READY, AR_READY, B_VALID, R_VALID, B_RESP, R_RESP}, R_DATA);
    else passed++;
    A_RSTn = 1; R_READY = 1;
    tick(); tick();
    total++;
    if (B_VALID !== 1'b0) $display("FAIL midreset_no_b: got %b expected 0", B_VALID);
    else passed++;
    do_read(8'h04, d, r, ok);
    total++;
    if (!ok || d !== 32'h0) $display("FAIL midreset_regs_clear: got ok=%0d %h expected 00000000", ok, d);
    else passed++;
    do_read(8'h18, d, r, ok);
    total++;
    if (!ok || d !== 32'h0) $display("FAIL midreset_write_dropped: got ok=%0d %h expected 00000000", ok, d);
    else passed++;
  endtask

  initial begin
    A_RSTn = 0; AW_VALID = 0; AW_ADDR = '0; AW_PROT = 3'b000;
    W_VALID = 0; W_DATA = '0; W_STRB = '0; B_READY = 1;
    AR_VALID = 0; AR_ADDR = '0; AR_PROT = 3'b000; R_READY = 1;
    test_reset();
    test_write_basic();
    test_strobe_w_first();
    test_ro_and_decode();
    test_collision();
    test_b_backpressure();
    test_r_backpressure();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
